lcd_text_engine: RTL and testbench
==================================

# lcd_text_engine

- Downstream stage of the vending-machine main FSM, driving a 16x2 HD44780-compatible character LCD in 8-bit write-only mode.
- Accepts a start request carrying item number, quantity, price and message index, and formats two 16-character lines from a fixed message set.
- Runs power-on initialisation, writes the display, then pulses `done` for one cycle.

## Interface
- `T_EN`, 25: `lcd_en` high width in clocks (500 ns at 50 MHz).
- `T_CMD`, 2500: wait after each non-clear write, in clocks (50 us).
- `T_CLR`, 100000: wait after clear command 0x01, in clocks (2 ms).
- `T_PWR`, 1000000: power-on wait before init, in clocks (20 ms).
- `clk` input 1: single clock; all flops on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled high in IDLE.
- `item` input 2: item number 0..3.
- `qty` input 3: quantity 0..7.
- `price` input 8: price in rupees, 0..255.
- `msg_index` input 4: message select.
- `done` output 1: one-cycle pulse when a message has been fully written.
- `lcd` output 8: LCD data bus.
- `lcd_rs` output 1: 0 = command, 1 = character.
- `lcd_rw` output 1: tied 0.
- `lcd_en` output 1: LCD enable strobe.

## Operation
- Reset values: `done`=0, `lcd`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, state PWR_WAIT, pending flag 0.
- PWR_WAIT: counts T_PWR clocks, then enters INIT.
- INIT: writes commands 0x38, 0x0C, 0x06, 0x01 with rs=0, then enters IDLE.
- IDLE: on `start`=1 enters LATCH.
- Start during PWR_WAIT/INIT: sets the pending flag. On INIT exit with pending set, go directly to LATCH and clear the flag.
- Start while busy (LATCH..DONE): ignored; no queueing.
- LATCH: one cycle. Registers `item`, `qty`, `price`, `msg_index` at its end. Upstream holds inputs stable from the cycle after `start` through this edge.
- BCD: starts `bin8_to_bcd3` on the latched price; waits for its done (8 cycles); digits stored.
- CLEAR: writes 0x01.
- ADDR1: writes 0x80.
- LINE1: 16 character writes, index 0..15.
- ADDR2: writes 0xC0.
- LINE2: 16 character writes.
- DONE: `done`=1 for one cycle, then IDLE.
- Item names (5 chars): 0 "-----", 1 "PEPSI", 2 "LAYS ", 3 "COKE ".
- ppp is three ASCII digits with leading zeros (price 7 = "007"). q is ASCII '0'+qty.
- msg 1 or 2: L1 "<NAME> Rs.ppp", L2 "QTY q".
- msg 3: L1 "INSERT MONEY", L2 "Rs.ppp".
- msg 4: L1 "SOLD OUT", L2 "<NAME>".
- msg 0 or 5..15: both lines all spaces (0x20).
- All lines right-padded with 0x20 to 16 characters.
- Reset mid-operation: immediate return to reset values and PWR_WAIT; full init is redone. No `done` for the aborted message.

## Timing
- Byte write sequence:
  - SETUP: 1 cycle; `lcd`/`lcd_rs` driven.
  - EN_HI: T_EN cycles with `lcd_en`=1.
  - EN_LO: 1 cycle hold with data unchanged.
  - WAIT: T_CMD cycles, or T_CLR when the command byte is 0x01.
- `lcd`/`lcd_rs` change only in SETUP, never while `lcd_en`=1.
- Message latency: `start` to `done` = 1 (LATCH) + 9 (BCD incl. handshake) + 35 writes. 34 writes cost (T_EN+2+T_CMD) each; the clear costs (T_EN+2+T_CLR).
- Back-to-back: `start` asserted in the cycle after `done` is accepted (IDLE reached).
- One shared 20-bit down-counter for all waits; loading it with value N yields exactly N wait cycles.

## Structure
- Package `vend_lcd_pkg`:
  - Command constants (FUNC_SET=0x38, DISP_ON=0x0C, ENTRY=0x06, CLR=0x01, LINE1=0x80, LINE2=0xC0).
  - State enum and the item-name ROM.
  - Function `char_at(msg, line, idx, ...)` returning the character byte.
- Sub-module `bin8_to_bcd3`:
  - Sequential double-dabble, `start`/`done`, 8 shift cycles.
  - Outputs hundreds/tens/units, 4 bits each.

## Test plan
All tests use T_EN=2, T_CMD=5, T_CLR=10, T_PWR=20.
- Init: release reset -> 20 idle clocks, then bytes 0x38, 0x0C, 0x06, 0x01 with rs=0 and correct gaps; `done` stays 0.
- msg 1, item 1, qty 5, price 15: captured bus is L1 "PEPSI Rs.015", L2 "QTY 5", padded to 16 each. `done` pulses exactly once.
- Start 1 cycle after reset release (msg 2, item 2, qty 5, price 16): pending flag holds the request. After init, "LAYS  Rs.016" / "QTY 5" is written.
- msg 3, price 255 -> "Rs.255". msg 0 and msg 9 -> 32 spaces. Price 0 -> "000".
- Second `start` pulsed mid-LINE1: ignored; exactly one `done`.
- `rst`=0 asserted during LINE2: all outputs 0 asynchronously (same cycle). After release, full init repeats; no `done` for the aborted message.

Source files
------------

// File: rtl/vend_lcd_pkg.sv
// Shared constants, state encodings and the character generator for the
// vending-machine LCD text engine.
package vend_lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLR      = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] SP           = 8'h20;

  localparam logic [3:0][7:0]  INIT_SEQ  = {CMD_CLR, CMD_ENTRY, CMD_DISP_ON, CMD_FUNC_SET};
  localparam logic [3:0][39:0] ITEM_NAME = {"COKE ", "LAYS ", "PEPSI", "-----"};

  typedef enum logic [3:0] {
    ST_PWR_WAIT, ST_INIT, ST_IDLE, ST_LATCH, ST_BCD, ST_CLEAR,
    ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2, ST_DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_EN_HI, PH_EN_LO, PH_WAIT} phase_t;

  function automatic logic is_write(input state_t s);
    return s inside {ST_INIT, ST_CLEAR, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2};
  endfunction

  // Builds the whole 16-char line, then picks column idx (column 0 in the MSBs).
  function automatic logic [7:0] char_at(input logic [3:0] msg, input logic line,
                                         input logic [3:0] idx, input logic [1:0] item,
                                         input logic [2:0] qty, input logic [3:0] h,
                                         input logic [3:0] t, input logic [3:0] u);
    logic [127:0] l;
    logic [39:0]  nm;
    logic [23:0]  ppp;
    nm  = ITEM_NAME[item];
    ppp = {4'h3, h, 4'h3, t, 4'h3, u};
    l   = {16{SP}};
    case (msg)
      4'd1, 4'd2: l = line ? {"QTY ", 5'b00110, qty, {11{SP}}} : {nm, " Rs.", ppp, {4{SP}}};
      4'd3:       l = line ? {"Rs.", ppp, {10{SP}}} : {"INSERT MONEY", {4{SP}}};
      4'd4:       l = line ? {nm, {11{SP}}} : {"SOLD OUT", {8{SP}}};
      default:    l = {16{SP}};
    endcase
    return l[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_text_engine_if.sv
// Request and LCD-bus signals between the upstream FSM, the engine and the panel.
interface lcd_text_engine_if;
  logic       start;
  logic [1:0] item;
  logic [2:0] qty;
  logic [7:0] price;
  logic [3:0] msg_index;
  logic       done;
  logic [7:0] lcd;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (output start, item, qty, price, msg_index,
                  input  done, lcd, lcd_rs, lcd_rw, lcd_en);
  modport slave  (input  start, item, qty, price, msg_index,
                  output done, lcd, lcd_rs, lcd_rw, lcd_en);
endinterface

// File: rtl/bin8_to_bcd3.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 shift cycles.
module bin8_to_bcd3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);
  logic [19:0] r_sh;
  logic [3:0]  r_cnt;
  logic        r_done;

  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int d = 0; d < 3; d++)
      if (a[8+4*d +: 4] >= 4'd5) a[8+4*d +: 4] = a[8+4*d +: 4] + 4'd3;
    return a << 1;
  endfunction

  // The start cycle already performs the first shift (no adjust needed on zero digits).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (start) begin
      r_sh   <= {12'd0, din} << 1;
      r_cnt  <= 4'd7;
      r_done <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_sh   <= dabble(r_sh);
      r_cnt  <= r_cnt - 4'd1;
      r_done <= (r_cnt == 4'd1);
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done     = r_done;
  assign hundreds = r_sh[19:16];
  assign tens     = r_sh[15:12];
  assign units    = r_sh[11:8];
endmodule

// File: rtl/lcd_text_engine.sv
// HD44780 8-bit write-only driver: power-on init, then formats and writes two
// 16-char lines per request and pulses done.
module lcd_text_engine
  import vend_lcd_pkg::*;
#(
  parameter int unsigned T_EN  = 25,
  parameter int unsigned T_CMD = 2500,
  parameter int unsigned T_CLR = 100000,
  parameter int unsigned T_PWR = 1000000
) (
  input logic              clk,
  input logic              rst,
  lcd_text_engine_if.slave bus
);
  localparam int CW = 20;

  state_t        r_state, w_nstate;
  phase_t        r_ph, w_nph;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [3:0]    r_idx, w_nidx;
  logic          r_pend, w_npend, w_byte_end;
  logic [1:0]    r_item;
  logic [2:0]    r_qty;
  logic [7:0]    r_price;
  logic [3:0]    r_msg;
  logic          r_done, r_en, r_rs, r_bcd_go;
  logic [7:0]    r_lcd, w_byte;
  logic          w_rs, w_bcd_done;
  logic [3:0]    w_h, w_t, w_u;

  bin8_to_bcd3 u_bcd (
    .clk(clk), .rst(rst), .start(r_bcd_go), .din(r_price),
    .done(w_bcd_done), .hundreds(w_h), .tens(w_t), .units(w_u)
  );

  always_comb begin
    w_nstate   = r_state;
    w_nph      = r_ph;
    w_ncnt     = r_cnt;
    w_nidx     = r_idx;
    w_npend    = r_pend | (bus.start & (r_state == ST_PWR_WAIT || r_state == ST_INIT));
    w_byte_end = 1'b0;
    if (is_write(r_state)) begin
      case (r_ph)
        PH_SETUP: begin w_nph = PH_EN_HI; w_ncnt = CW'(T_EN - 1); end
        PH_EN_HI: if (r_cnt == '0) w_nph = PH_EN_LO; else w_ncnt = r_cnt - 20'd1;
        PH_EN_LO: begin
          w_nph  = PH_WAIT;
          w_ncnt = (!r_rs && r_lcd == CMD_CLR) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
        end
        default:  if (r_cnt == '0) begin w_nph = PH_SETUP; w_byte_end = 1'b1; end
                  else w_ncnt = r_cnt - 20'd1;
      endcase
    end
    case (r_state)
      ST_PWR_WAIT: if (r_cnt == '0) begin
                     w_nstate = ST_INIT; w_nidx = '0; w_nph = PH_SETUP;
                   end else w_ncnt = r_cnt - 20'd1;
      ST_INIT:     if (w_byte_end) begin
                     if (r_idx == 4'd3) begin
                       w_nstate = w_npend ? ST_LATCH : ST_IDLE;
                       w_npend  = 1'b0;
                     end else w_nidx = r_idx + 4'd1;
                   end
      ST_IDLE:     if (bus.start) w_nstate = ST_LATCH;
      ST_LATCH:    w_nstate = ST_BCD;
      ST_BCD:      if (w_bcd_done) w_nstate = ST_CLEAR;
      ST_CLEAR:    if (w_byte_end) w_nstate = ST_ADDR1;
      ST_ADDR1:    if (w_byte_end) begin w_nstate = ST_LINE1; w_nidx = '0; end
      ST_LINE1:    if (w_byte_end) begin
                     if (r_idx == 4'd15) w_nstate = ST_ADDR2; else w_nidx = r_idx + 4'd1;
                   end
      ST_ADDR2:    if (w_byte_end) begin w_nstate = ST_LINE2; w_nidx = '0; end
      ST_LINE2:    if (w_byte_end) begin
                     if (r_idx == 4'd15) w_nstate = ST_DONE; else w_nidx = r_idx + 4'd1;
                   end
      ST_DONE:     w_nstate = ST_IDLE;
      default:     w_nstate = ST_PWR_WAIT;
    endcase
  end

  // Byte for the write about to start; loaded on the edge entering SETUP.
  always_comb begin
    w_byte = 8'h00;
    w_rs   = 1'b0;
    case (w_nstate)
      ST_INIT:  w_byte = INIT_SEQ[w_nidx[1:0]];
      ST_CLEAR: w_byte = CMD_CLR;
      ST_ADDR1: w_byte = CMD_LINE1;
      ST_ADDR2: w_byte = CMD_LINE2;
      ST_LINE1, ST_LINE2: begin
        w_rs   = 1'b1;
        w_byte = char_at(r_msg, w_nstate == ST_LINE2, w_nidx, r_item, r_qty, w_h, w_t, w_u);
      end
      default:  w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_PWR_WAIT;
      r_ph     <= PH_SETUP;
      r_cnt    <= CW'(T_PWR - 1);
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_item   <= '0;
      r_qty    <= '0;
      r_price  <= '0;
      r_msg    <= '0;
      r_done   <= 1'b0;
      r_en     <= 1'b0;
      r_rs     <= 1'b0;
      r_lcd    <= '0;
      r_bcd_go <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_ph     <= w_nph;
      r_cnt    <= w_ncnt;
      r_idx    <= w_nidx;
      r_pend   <= w_npend;
      r_done   <= (w_nstate == ST_DONE);
      r_en     <= is_write(w_nstate) && (w_nph == PH_EN_HI);
      r_bcd_go <= (r_state == ST_LATCH);
      if (r_state == ST_LATCH) begin
        r_item  <= bus.item;
        r_qty   <= bus.qty;
        r_price <= bus.price;
        r_msg   <= bus.msg_index;
      end
      if (is_write(w_nstate) && w_nph == PH_SETUP) begin
        r_lcd <= w_byte;
        r_rs  <= w_rs;
      end
    end
  end

  assign bus.done   = r_done;
  assign bus.lcd    = r_lcd;
  assign bus.lcd_rs = r_rs;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_en = r_en;
endmodule

// File: tb/tb_lcd_text_engine.sv
// Self-checking bench: a bus monitor pops an expected-byte scoreboard on each
// enable rise; message vectors come from a table of literal display lines.
module tb_lcd_text_engine;
  localparam int T_EN = 2, T_CMD = 5, T_CLR = 10, T_PWR = 20;
  // LATCH + BCD + 34 normal writes + the clear, then done in the following cycle
  localparam int LAT = 1 + 9 + 34 * (T_EN + 2 + T_CMD) + (T_EN + 2 + T_CLR) + 1;

  typedef struct packed {
    logic [3:0]   msg;
    logic [1:0]   item;
    logic [2:0]   qty;
    logic [7:0]   price;
    logic [127:0] l1;
    logic [127:0] l2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  lcd_text_engine_if bif ();

  lcd_text_engine #(.T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  int         cyc = 0, done_cnt = 0, last_rise = 0, rel_cyc = 0;
  logic [8:0] exp_q[$];
  int         rise_q[$];
  logic [8:0] cap;
  logic       prev_en = 1'b0;
  vec_t       vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (bif.done) done_cnt++;
      if (bif.lcd_en && !prev_en) begin
        cap       = {bif.lcd_rs, bif.lcd};
        last_rise = cyc;
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got %0h expected none", cap);
        end else chk("lcd_byte", {bif.lcd_rw, bif.lcd_rs, bif.lcd}, {1'b0, exp_q.pop_front()});
      end
      if (!bif.lcd_en && prev_en) begin
        chk("en_width", cyc - last_rise, T_EN);
        chk("data_hold", {bif.lcd_rs, bif.lcd}, cap);
      end
      prev_en = bif.lcd_en;
    end else prev_en = 1'b0;
  end

  function automatic logic [7:0] line_ch(input logic [127:0] s, input int i);
    int n = 0;
    for (int k = 0; k < 16; k++) if (s[8*k +: 8] != 8'h00) n = k + 1;
    if (i < n) return s[8*(n-1-i) +: 8];
    return 8'h20;
  endfunction

  task automatic push_init();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
  endtask

  task automatic push_msg(input vec_t v);
    exp_q.push_back(9'h001); exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line_ch(v.l1, i)});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, line_ch(v.l2, i)});
  endtask

  task automatic drive(input vec_t v);
    bif.msg_index = v.msg; bif.item = v.item; bif.qty = v.qty; bif.price = v.price;
  endtask

  task automatic release_rst();
    @(negedge clk); #1;
    rst = 1'b1; rel_cyc = cyc; rise_q.delete(); push_init();
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_left(input int left, input int budget);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin @(negedge clk); #1; n++; end
    chk("reach_point", (exp_q.size() <= left), 1);
  endtask

  task automatic wait_done(input string name, input int budget, output int at);
    int n = 0;
    at = -1;
    while (n < budget) begin
      @(negedge clk); #1; n++;
      if (bif.done) begin at = cyc; break; end
    end
    checks++;
    if (at < 0) begin failures++; $display("FAIL %s: done not seen, required within %0d", name, budget); end
  endtask

  task automatic check_init(input string name);
    wait_empty(name, 200);
    repeat (T_CLR + 10) @(negedge clk);
    #1;
    chk({name, "_writes"}, rise_q.size(), 4);
    if (rise_q.size() >= 4) begin
      chk({name, "_pwr_gap"}, rise_q[0] - rel_cyc, T_PWR + 1);
      for (int i = 1; i < 4; i++) chk({name, "_gap"}, rise_q[i] - rise_q[i-1], T_EN + 2 + T_CMD);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t0, td, d0;
    @(negedge clk); #1;
    drive(v); bif.start = 1'b1;
    push_msg(v); t0 = cyc; d0 = done_cnt;
    @(negedge clk); #1; bif.start = 1'b0;
    wait_done(name, 2000, td);
    if (td >= 0) chk({name, "_latency"}, td - t0, LAT);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int td, d0;
    vec_t v;
    vecs[0] = '{4'd1, 2'd1, 3'd5, 8'd15,  128'("PEPSI Rs.015"), 128'("QTY 5")};
    vecs[1] = '{4'd3, 2'd0, 3'd0, 8'd255, 128'("INSERT MONEY"), 128'("Rs.255")};
    vecs[2] = '{4'd0, 2'd3, 3'd7, 8'd99,  128'(0), 128'(0)};
    vecs[3] = '{4'd9, 2'd2, 3'd1, 8'd7,   128'(0), 128'(0)};
    vecs[4] = '{4'd4, 2'd3, 3'd2, 8'd0,   128'("SOLD OUT"), 128'("COKE ")};
    vecs[5] = '{4'd2, 2'd0, 3'd0, 8'd0,   128'("----- Rs.000"), 128'("QTY 0")};
    vecs[6] = '{4'd2, 2'd3, 3'd7, 8'd200, 128'("COKE  Rs.200"), 128'("QTY 7")};

    rst = 1'b1; bif.start = 1'b0; bif.item = '0; bif.qty = '0; bif.price = '0; bif.msg_index = '0;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", bif.done, 0);
    chk("rst_lcd", bif.lcd, 0);
    chk("rst_rs", bif.lcd_rs, 0);
    chk("rst_rw", bif.lcd_rw, 0);
    chk("rst_en", bif.lcd_en, 0);

    release_rst();
    check_init("init");
    chk("init_no_done", done_cnt, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // request arriving during power-on wait is held and served after init
    @(negedge clk); #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    release_rst();
    @(negedge clk); #1;
    v = '{4'd2, 2'd2, 3'd5, 8'd16, 128'("LAYS  Rs.016"), 128'("QTY 5")};
    drive(v); bif.start = 1'b1; push_msg(v);
    @(negedge clk); #1; bif.start = 1'b0;
    wait_done("pending", 3000, td);
    chk("pending_done_once", done_cnt - d0, 1);
    chk("pending_drained", exp_q.size(), 0);

    // second start in LINE1 is dropped
    @(negedge clk); #1;
    v = '{4'd4, 2'd1, 3'd0, 8'd0, 128'("SOLD OUT"), 128'("PEPSI")};
    drive(v); bif.start = 1'b1; push_msg(v); d0 = done_cnt;
    @(negedge clk); #1; bif.start = 1'b0;
    wait_left(26, 1000);
    bif.msg_index = 4'd3; bif.price = 8'd99; bif.item = 2'd3; bif.start = 1'b1;
    @(negedge clk); #1; bif.start = 1'b0;
    wait_done("busy_start", 2000, td);
    repeat (400) @(negedge clk);
    #1;
    chk("busy_done_once", done_cnt - d0, 1);
    chk("busy_drained", exp_q.size(), 0);

    // reset during LINE2: async clear, no done, full re-init
    @(negedge clk); #1;
    v = '{4'd1, 2'd2, 3'd3, 8'd128, 128'("LAYS  Rs.128"), 128'("QTY 3")};
    drive(v); bif.start = 1'b1; push_msg(v); d0 = done_cnt;
    @(negedge clk); #1; bif.start = 1'b0;
    wait_left(8, 1000);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("abort_lcd", bif.lcd, 0);
    chk("abort_rs", bif.lcd_rs, 0);
    chk("abort_en", bif.lcd_en, 0);
    chk("abort_done", bif.done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    release_rst();
    check_init("reinit");
    chk("abort_no_done", done_cnt - d0, 0);
    run_vec(vecs[1], "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached, required completion");
    $fatal(1);
  end
endmodule
